uart_tx: RTL and testbench

// - UART transmitter: serialises one byte per valid/ready handshake onto a 1-wire line, 8N1 (8O1/8E1 with parity).
// - Transmit-side peer of the baud generator and receiver in the UART subsystem.
// - Owns its own bit-period counter, which starts at the bit edge with no mid-bit offset.
// - Driven by the APB UART register block; tx is routed to the pad.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_tx_bit_timer.sv | 37 +++
 rtl/uart_tx.sv | 169 ++++++++++++++++
 tb/tb_uart_tx.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared UART types and constants (FSM encoding, divider width,
//           default 50 MHz divisors used by the tx, rx and baud generator).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int DIV_W = 16;

  localparam int C_DIV_9600_50M   = 5208;
  localparam int C_DIV_115200_50M = 434;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  // A divisor below 2 would produce a zero- or one-cycle bit; force a floor of 2.
  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] div);
    return (div < DIV_W'(2)) ? DIV_W'(2) : div;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_bit_timer.sv
// ============================================================================
// Module  : uart_tx_bit_timer
// Brief   : Bit-period counter for the UART transmitter; pulses o_bit_end on
//           the last cycle of each bit and restarts at 0 for the next bit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_bit_timer
  import uart_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] i_div,
  input  logic             i_clear,
  output logic             o_bit_end
);

  logic [DIV_W-1:0] r_cnt;
  logic             w_last;

  assign w_last    = (r_cnt == (i_div - DIV_W'(1)));
  assign o_bit_end = w_last && !i_clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + DIV_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
// Module  : uart_tx
// Brief   : UART transmitter, 8N1 by default; define UART_TX_PARITY_EN to
//           insert a parity bit after D7 (even, or odd with PARITY_ODD=1).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_DIV_LO = C_DIV_9600_50M,
  parameter int CLK_DIV_HI = C_DIV_115200_50M,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       baud_sel,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam logic [DIV_W-1:0] C_DIV_LO    = CLK_DIV_LO[DIV_W-1:0];
  localparam logic [DIV_W-1:0] C_DIV_HI    = CLK_DIV_HI[DIV_W-1:0];
  localparam logic [2:0]       C_LAST_STOP = 3'(STOP_BITS - 1);

  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
    $error("uart_tx: PARITY_ODD must be 0 or 1");
  end

  tx_state_e        r_state, w_state_nxt;
  logic [2:0]       r_idx, w_idx_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic [DIV_W-1:0] r_div, w_div_nxt;
  logic             r_tx, w_tx_nxt;
  logic             r_done, w_done_nxt;
  logic             w_timer_clr;
  logic             w_bit_end;

`ifdef UART_TX_PARITY_EN
  localparam logic C_PAR_ODD = (PARITY_ODD != 0);
  logic r_par, w_par_nxt;
`endif

  uart_tx_bit_timer u_bit_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_div     (r_div),
    .i_clear   (w_timer_clr),
    .o_bit_end (w_bit_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_shift <= '0;
      r_div   <= '0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_div   <= w_div_nxt;
      r_tx    <= w_tx_nxt;
      r_done  <= w_done_nxt;
`ifdef UART_TX_PARITY_EN
      r_par   <= w_par_nxt;
`endif
    end
  end

  // w_tx_nxt is the line level for the cycle after this edge, so tx stays a flop output.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_div_nxt   = r_div;
    w_tx_nxt    = r_tx;
    w_done_nxt  = 1'b0;
    w_timer_clr = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_par_nxt   = r_par;
`endif
    unique case (r_state)
      IDLE: begin
        w_timer_clr = 1'b1;
        w_tx_nxt    = 1'b1;
        if (tx_valid) begin
          w_state_nxt = START;
          w_shift_nxt = tx_data;
          w_idx_nxt   = 3'd0;
          w_div_nxt   = clamp_div(baud_sel ? C_DIV_HI : C_DIV_LO);
          w_tx_nxt    = 1'b0;
`ifdef UART_TX_PARITY_EN
          w_par_nxt   = (^tx_data) ^ C_PAR_ODD;
`endif
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state_nxt = DATA;
          w_tx_nxt    = r_shift[0];
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_shift_nxt = {1'b0, r_shift[7:1]};
          w_idx_nxt   = r_idx + 3'd1;
          if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state_nxt = PARITY;
            w_tx_nxt    = r_par;
`else
            w_state_nxt = STOP;
            w_tx_nxt    = 1'b1;
`endif
          end else begin
            w_tx_nxt = r_shift[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = STOP;
          w_tx_nxt    = 1'b1;
        end
      end
`endif
      STOP: begin
        w_tx_nxt = 1'b1;
        if (w_bit_end) begin
          if (r_idx == C_LAST_STOP) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_idx_nxt = r_idx + 3'd1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  assign tx       = r_tx;
  assign tx_done  = r_done;
  assign tx_ready = (r_state == IDLE);
  assign tx_busy  = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ============================================================================
// Module  : tb_uart_tx
// Brief   : Directed self-checking bench for uart_tx (8N1 default build, with
//           parity scenarios when UART_TX_PARITY_EN is defined).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int DHI = 434;
  localparam int DLO = 5208;

  logic       clk;
  logic       rst_n;
  logic       baud_sel;
  logic [7:0] tx_data;
  logic       valid_a, valid_b;
  logic       ready_a, tx_a, busy_a, done_a;
  logic       ready_b, tx_b, busy_b, done_b;

  int n_tests = 0;
  int n_fail  = 0;
  int sel     = 0;
  int done_cnt_a = 0;

  logic cap_q[$];
  int   cap_done, cap_wait, cap_ready_hi, cap_busy_lo;
  logic cap_ready_done, cap_busy_done;
  logic cur_tx, cur_done, cur_ready, cur_busy;

  uart_tx u_dut_a (
    .clk(clk), .rst_n(rst_n), .baud_sel(baud_sel), .tx_data(tx_data),
    .tx_valid(valid_a), .tx_ready(ready_a), .tx(tx_a), .tx_busy(busy_a), .tx_done(done_a)
  );

  uart_tx #(.STOP_BITS(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .baud_sel(baud_sel), .tx_data(tx_data),
    .tx_valid(valid_b), .tx_ready(ready_b), .tx(tx_b), .tx_busy(busy_b), .tx_done(done_b)
  );

`ifdef UART_TX_PARITY_EN
  logic valid_c, ready_c, tx_c, busy_c, done_c;
  uart_tx #(.PARITY_ODD(1)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .baud_sel(baud_sel), .tx_data(tx_data),
    .tx_valid(valid_c), .tx_ready(ready_c), .tx(tx_c), .tx_busy(busy_c), .tx_done(done_c)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done_a === 1'b1) done_cnt_a <= done_cnt_a + 1;

  always_comb begin
    cur_tx = tx_a; cur_done = done_a; cur_ready = ready_a; cur_busy = busy_a;
    if (sel == 1) begin
      cur_tx = tx_b; cur_done = done_b; cur_ready = ready_b; cur_busy = busy_b;
    end
`ifdef UART_TX_PARITY_EN
    if (sel == 2) begin
      cur_tx = tx_c; cur_done = done_c; cur_ready = ready_c; cur_busy = busy_c;
    end
`endif
  end

  task automatic set_valid(input int s, input logic v);
    if (s == 0) valid_a = v;
    if (s == 1) valid_b = v;
`ifdef UART_TX_PARITY_EN
    if (s == 2) valid_c = v;
`endif
  endtask

  task automatic start_tx(input int s, input logic [7:0] d, input logic b);
    @(negedge clk);
    sel = s; tx_data = d; baud_sel = b;
    set_valid(s, 1'b1);
  endtask

  // Records the line from the first low cycle up to (not including) the tx_done cycle.
  task automatic capture(input int limit, input bit drop);
    int w;
    cap_q.delete();
    cap_done = -1; cap_ready_hi = 0; cap_busy_lo = 0;
    cap_ready_done = 1'bx; cap_busy_done = 1'bx;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (cur_tx !== 1'b0 && w < 50);
    cap_wait = (cur_tx === 1'b0) ? w : -1;
    if (cap_wait < 0) return;
    if (drop) set_valid(sel, 1'b0);
    for (int c = 0; c < limit; c++) begin
      if (c > 0) @(negedge clk);
      if (cur_done === 1'b1) begin
        cap_done = c; cap_ready_done = cur_ready; cap_busy_done = cur_busy;
        break;
      end
      cap_q.push_back(cur_tx);
      if (cur_ready !== 1'b0) cap_ready_hi++;
      if (cur_busy !== 1'b1) cap_busy_lo++;
    end
  endtask

  function automatic logic [7:0] decode(input int div);
    logic [7:0] d;
    int i;
    for (int k = 0; k < 8; k++) begin
      i = (k + 1) * div + div / 2;
      d[k] = (i < cap_q.size()) ? cap_q[i] : 1'bx;
    end
    return d;
  endfunction

  function automatic logic bit_at(input int idx, input int div);
    int i;
    i = idx * div + div / 2;
    return (i < cap_q.size()) ? cap_q[i] : 1'bx;
  endfunction

  function automatic int glitches(input int div, input int nbits);
    int n;
    n = 0;
    if (cap_q.size() < nbits * div) return -1;
    for (int i = 0; i < nbits * div; i++) if (cap_q[i] !== cap_q[(i / div) * div]) n++;
    return n;
  endfunction

  function automatic int count_ones(input int from, input int to);
    int n;
    n = 0;
    for (int i = from; i < to; i++) if (i < cap_q.size() && cap_q[i] === 1'b1) n++;
    return n;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; valid_a = 1'b0; valid_b = 1'b0; baud_sel = 1'b1; tx_data = 8'h00;
`ifdef UART_TX_PARITY_EN
    valid_c = 1'b0;
`endif
    repeat (5) @(negedge clk);
    n_tests++; if (tx_a !== 1'b1) begin n_fail++; $display("FAIL reset_tx got %b want 1", tx_a); end
    n_tests++; if (ready_a !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", ready_a); end
    n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy_a); end
    n_tests++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done_a); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++; if ({tx_b, ready_b, busy_b} !== 3'b110) begin n_fail++; $display("FAIL reset_b_idle got %b want 110", {tx_b, ready_b, busy_b}); end
  endtask

  task automatic test_single();
    int lows;
    start_tx(0, 8'h55, 1'b1);
    fork
      capture(NB * DHI + 100, 1'b1);
      begin
        repeat (1500) @(negedge clk);
        valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
      end
    join
    n_tests++; if (cap_wait !== 1) begin n_fail++; $display("FAIL single_latency got %0d want 1", cap_wait); end
    n_tests++; if (cap_done !== NB * DHI) begin n_fail++; $display("FAIL single_done_time got %0d want %0d", cap_done, NB * DHI); end
    n_tests++; if (decode(DHI) !== 8'h55) begin n_fail++; $display("FAIL single_data got %h want 55", decode(DHI)); end
    n_tests++; if (glitches(DHI, NB) !== 0) begin n_fail++; $display("FAIL single_bit_windows got %0d want 0", glitches(DHI, NB)); end
    n_tests++; if (count_ones((NB - 1) * DHI, NB * DHI) !== DHI) begin n_fail++; $display("FAIL single_stop got %0d want %0d", count_ones((NB - 1) * DHI, NB * DHI), DHI); end
    n_tests++; if ({cap_ready_hi, cap_busy_lo} !== {32'd0, 32'd0}) begin n_fail++; $display("FAIL single_busy_flags got ready_hi=%0d busy_lo=%0d want 0 0", cap_ready_hi, cap_busy_lo); end
    n_tests++; if ({cap_ready_done, cap_busy_done} !== 2'b10) begin n_fail++; $display("FAIL single_idle_at_done got %b want 10", {cap_ready_done, cap_busy_done}); end
    lows = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_a !== 1'b1) lows++;
    end
    n_tests++; if (lows !== 0) begin n_fail++; $display("FAIL ignored_valid_while_busy got %0d low cycles want 0", lows); end
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = done_cnt_a;
    start_tx(0, 8'hA3, 1'b1);
    capture(NB * DHI + 100, 1'b0);
    tx_data = 8'h0F;
    n_tests++; if (cap_done !== NB * DHI) begin n_fail++; $display("FAIL b2b_f1_done got %0d want %0d", cap_done, NB * DHI); end
    n_tests++; if (decode(DHI) !== 8'hA3) begin n_fail++; $display("FAIL b2b_f1_data got %h want a3", decode(DHI)); end
    n_tests++; if (glitches(DHI, NB) !== 0) begin n_fail++; $display("FAIL b2b_f1_windows got %0d want 0", glitches(DHI, NB)); end
    capture(NB * DHI + 100, 1'b1);
    n_tests++; if (cap_wait !== 1) begin n_fail++; $display("FAIL b2b_gap got %0d want 1", cap_wait); end
    n_tests++; if (cap_done !== NB * DHI) begin n_fail++; $display("FAIL b2b_f2_done got %0d want %0d", cap_done, NB * DHI); end
    n_tests++; if (decode(DHI) !== 8'h0F) begin n_fail++; $display("FAIL b2b_f2_data got %h want 0f", decode(DHI)); end
    n_tests++; if (glitches(DHI, NB) !== 0) begin n_fail++; $display("FAIL b2b_f2_windows got %0d want 0", glitches(DHI, NB)); end
    repeat (10) @(negedge clk);
    n_tests++; if (done_cnt_a - d0 !== 2) begin n_fail++; $display("FAIL b2b_done_pulses got %0d want 2", done_cnt_a - d0); end
  endtask

  task automatic test_settings_held();
    start_tx(1, 8'hC5, 1'b0);
    fork
      capture((NB + 1) * DLO + 100, 1'b1);
      begin
        repeat (3000) @(negedge clk);
        tx_data = 8'h3A; baud_sel = 1'b1;
        repeat (20000) @(negedge clk);
        tx_data = 8'hFF; baud_sel = 1'b0;
        repeat (20000) @(negedge clk);
        baud_sel = 1'b1;
      end
    join
    n_tests++; if (cap_wait !== 1) begin n_fail++; $display("FAIL held_latency got %0d want 1", cap_wait); end
    n_tests++; if (cap_done !== (NB + 1) * DLO) begin n_fail++; $display("FAIL held_done_time got %0d want %0d", cap_done, (NB + 1) * DLO); end
    n_tests++; if (decode(DLO) !== 8'hC5) begin n_fail++; $display("FAIL held_data got %h want c5", decode(DLO)); end
    n_tests++; if (glitches(DLO, NB + 1) !== 0) begin n_fail++; $display("FAIL held_bit_windows got %0d want 0", glitches(DLO, NB + 1)); end
    n_tests++; if (count_ones((NB - 1) * DLO, (NB + 1) * DLO) !== 2 * DLO) begin n_fail++; $display("FAIL held_stop2 got %0d want %0d", count_ones((NB - 1) * DLO, (NB + 1) * DLO), 2 * DLO); end
  endtask

  task automatic test_reset_midframe();
    int w;
    start_tx(0, 8'h00, 1'b1);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (tx_a !== 1'b0 && w < 50);
    valid_a = 1'b0;
    repeat (4 * DHI + 200) @(negedge clk);
    n_tests++; if ({tx_a, busy_a} !== 2'b01) begin n_fail++; $display("FAIL midrst_in_d3 got tx/busy %b want 01", {tx_a, busy_a}); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (tx_a !== 1'b1) begin n_fail++; $display("FAIL midrst_async_tx got %b want 1", tx_a); end
    n_tests++; if ({ready_a, busy_a} !== 2'b10) begin n_fail++; $display("FAIL midrst_async_flags got %b want 10", {ready_a, busy_a}); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if ({tx_a, ready_a, done_a} !== 3'b110) begin n_fail++; $display("FAIL midrst_release got %b want 110", {tx_a, ready_a, done_a}); end
    start_tx(0, 8'h81, 1'b1);
    capture(NB * DHI + 100, 1'b1);
    n_tests++; if (cap_done !== NB * DHI) begin n_fail++; $display("FAIL midrst_new_done got %0d want %0d", cap_done, NB * DHI); end
    n_tests++; if (decode(DHI) !== 8'h81) begin n_fail++; $display("FAIL midrst_new_data got %h want 81", decode(DHI)); end
    n_tests++; if (glitches(DHI, NB) !== 0) begin n_fail++; $display("FAIL midrst_new_windows got %0d want 0", glitches(DHI, NB)); end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    start_tx(0, 8'h07, 1'b1);
    capture(11 * DHI + 100, 1'b1);
    n_tests++; if (cap_done !== 11 * DHI) begin n_fail++; $display("FAIL par_even_len got %0d want %0d", cap_done, 11 * DHI); end
    n_tests++; if (bit_at(9, DHI) !== 1'b1) begin n_fail++; $display("FAIL par_even_bit got %b want 1", bit_at(9, DHI)); end
    n_tests++; if (decode(DHI) !== 8'h07) begin n_fail++; $display("FAIL par_even_data got %h want 07", decode(DHI)); end
    start_tx(2, 8'h07, 1'b1);
    capture(11 * DHI + 100, 1'b1);
    n_tests++; if (cap_done !== 11 * DHI) begin n_fail++; $display("FAIL par_odd_len got %0d want %0d", cap_done, 11 * DHI); end
    n_tests++; if (bit_at(9, DHI) !== 1'b0) begin n_fail++; $display("FAIL par_odd_bit got %b want 0", bit_at(9, DHI)); end
    n_tests++; if (glitches(DHI, 11) !== 0) begin n_fail++; $display("FAIL par_odd_windows got %0d want 0", glitches(DHI, 11)); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_midframe();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_settings_held();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
